// File: rtl/tile_pkg.sv
// Definitions shared by the tile loader and the tile storer: beat geometry
// helpers, BRAM bank address composition and the storer state type.
package tile_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } storer_state_t;

    // Elements carried by one bus beat.
    function automatic int epp_of(input int busw, input int w);
        return busw / w;
    endfunction

    // Bytes occupied by one element.
    function automatic int bpe_of(input int w);
        return w / 8;
    endfunction

    // Bank address {sel, idx[aw-2:0]}: the MSB picks the double-buffer half.
    function automatic logic [31:0] bank_addr(input logic sel, input logic [31:0] idx, input int aw);
        logic [31:0] mask;
        mask = (32'd1 << (aw - 1)) - 32'd1;
        return ({31'd0, sel} << (aw - 1)) | (idx & mask);
    endfunction

endpackage

// File: rtl/tile_storer_if.sv
// Avalon-MM write master bundle between the tile storer and the f2sdram port.
interface tile_storer_if #(
    parameter int BUSW = 128
);
    logic [31:0]       avm_address;
    logic              avm_write;
    logic [BUSW-1:0]   avm_writedata;
    logic [BUSW/8-1:0] avm_byteenable;
    logic [7:0]        avm_burstcount;
    logic              avm_waitrequest;

    modport master (
        output avm_address, avm_write, avm_writedata, avm_byteenable, avm_burstcount,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_write, avm_writedata, avm_byteenable, avm_burstcount,
        output avm_waitrequest
    );
endinterface

// File: rtl/beat_packer.sv
// Assembles returning BRAM elements into one bus beat and tracks which byte
// lanes hold real data, so a short final beat is zero-padded and masked.
module beat_packer
    import tile_pkg::*;
#(
    parameter int W    = 8,
    parameter int BUSW = 128,
    localparam int EPP = epp_of(BUSW, W),
    localparam int BPE = bpe_of(W),
    localparam int SW  = (EPP > 1) ? $clog2(EPP) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [SW-1:0]     slot,
    input  logic [W-1:0]      elem,
    output logic [BUSW-1:0]   beat,
    output logic [BUSW/8-1:0] byteenable
);
    logic [EPP-1:0] filled;

    // Pack register; cleared between beats so unused slots go out as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat   <= '0;
            filled <= '0;
        end else if (clear) begin
            beat   <= '0;
            filled <= '0;
        end else if (load) begin
            beat[slot*W +: W] <= elem;
            filled[slot]      <= 1'b1;
        end
    end

    // Byte lanes are enabled only for slots that received an element.
    always_comb begin
        byteenable = '0;
        for (int j = 0; j < EPP; j++) begin
            byteenable[j*BPE +: BPE] = {BPE{filled[j]}};
        end
    end
endmodule

// File: rtl/tile_storer.sv
// Tile writeback engine: streams a result tile out of the banked BRAM
// (row-major, one element per cycle), packs it into beats and writes it to
// SDRAM as a single Avalon-MM burst.
module tile_storer
    import tile_pkg::*;
#(
    parameter int W            = 8,
    parameter int BUSW         = 128,
    parameter int T            = 16,
    parameter int AW           = 10,
    parameter int ADDR_IS_WORD = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [31:0]       base_addr_bytes,
    input  logic [15:0]       tile_rows,
    input  logic [15:0]       tile_cols,
    input  logic              bankset_sel,
    output logic [T-1:0]      r_en,
    output logic [T*AW-1:0]   r_addr,
    input  logic [T*W-1:0]    r_dout,
    tile_storer_if.master     avm
);
    localparam int EPP = epp_of(BUSW, W);
    localparam int SW  = (EPP > 1) ? $clog2(EPP) : 1;
    localparam int BKW = (T > 1) ? $clog2(T) : 1;
    localparam int CW  = BKW + 1;
    localparam int LSB = $clog2(BUSW / 8);
    localparam logic [SW:0] EPP_C = (SW + 1)'(EPP);

    storer_state_t state;
    logic [8:0]    ne_q, issued_q;
    logic [CW-1:0] cols_q, c_q;
    logic [BKW-1:0] r_q, iss_bank, rd_bank;
    logic          bsel_q;
    logic [7:0]    nb_q, beats_sent;
    logic [SW:0]   bi_q;
    logic [SW-1:0] iss_slot, rd_slot;
    logic          iss_last, rd_valid, rd_last;

    logic [31:0]    ne_full, aligned;
    logic [7:0]     nb_in;
    logic           fresh, accept, more, issue, clear;
    logic [BKW-1:0] cur_r;
    logic [CW-1:0]  cur_c, cur_cols;
    logic [8:0]     cur_ne, cur_issued;
    logic [SW:0]    cur_bi;
    logic           cur_bsel;
    logic [BUSW-1:0]   beat;
    logic [BUSW/8-1:0] beat_be;

    assign ne_full = 32'(tile_rows) * 32'(tile_cols);
    assign aligned = base_addr_bytes & ~(32'(BUSW / 8) - 32'd1);
    assign nb_in   = 8'((ne_full + 32'(EPP - 1)) / 32'(EPP));
    assign accept  = (state == S_WRITE) && avm.avm_write && !avm.avm_waitrequest;
    assign more    = (beats_sent + 8'd1) != nb_q;

    // In IDLE the read walk starts from the live inputs so the first read
    // goes out on the same edge that accepts start.
    always_comb begin
        fresh      = (state == S_IDLE);
        cur_r      = fresh ? '0 : r_q;
        cur_c      = fresh ? '0 : c_q;
        cur_cols   = fresh ? tile_cols[CW-1:0] : cols_q;
        cur_ne     = fresh ? 9'(ne_full) : ne_q;
        cur_issued = fresh ? '0 : issued_q;
        cur_bsel   = fresh ? bankset_sel : bsel_q;
        cur_bi     = (state == S_FETCH) ? bi_q : '0;
        clear      = (fresh && start && (ne_full != 32'd0)) || (accept && more);
        issue      = clear || ((state == S_FETCH) && (cur_bi < EPP_C) && (cur_issued < cur_ne));
    end

    beat_packer #(.W(W), .BUSW(BUSW)) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .load       (rd_valid),
        .slot       (rd_slot),
        .elem       (r_dout[rd_bank*W +: W]),
        .beat       (beat),
        .byteenable (beat_be)
    );

    assign avm.avm_writedata  = beat;
    assign avm.avm_byteenable = beat_be;

    // Main FSM with read issue, read-return tracking and Avalon control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            busy               <= 1'b0;
            done               <= 1'b0;
            r_en               <= '0;
            r_addr             <= '0;
            ne_q               <= '0;
            issued_q           <= '0;
            cols_q             <= '0;
            c_q                <= '0;
            r_q                <= '0;
            bsel_q             <= 1'b0;
            nb_q               <= '0;
            beats_sent         <= '0;
            bi_q               <= '0;
            iss_slot           <= '0;
            iss_last           <= 1'b0;
            iss_bank           <= '0;
            rd_valid           <= 1'b0;
            rd_slot            <= '0;
            rd_last            <= 1'b0;
            rd_bank            <= '0;
            avm.avm_address    <= '0;
            avm.avm_write      <= 1'b0;
            avm.avm_burstcount <= '0;
        end else begin
            rd_valid <= |r_en;
            rd_slot  <= iss_slot;
            rd_last  <= iss_last;
            rd_bank  <= iss_bank;

            if (issue) begin
                r_en                  <= T'(1) << cur_r;
                r_addr[cur_r*AW +: AW] <= AW'(bank_addr(cur_bsel, 32'(cur_c), AW));
                iss_slot              <= cur_bi[SW-1:0];
                iss_last              <= ((cur_bi + (SW + 1)'(1)) == EPP_C) || ((cur_issued + 9'd1) == cur_ne);
                iss_bank              <= cur_r;
                if ((cur_c + CW'(1)) == cur_cols) begin
                    c_q <= '0;
                    r_q <= cur_r + BKW'(1);
                end else begin
                    c_q <= cur_c + CW'(1);
                    r_q <= cur_r;
                end
                issued_q <= cur_issued + 9'd1;
                bi_q     <= cur_bi + (SW + 1)'(1);
            end else begin
                r_en <= '0;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (ne_full == 32'd0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state              <= S_FETCH;
                            busy               <= 1'b1;
                            ne_q               <= 9'(ne_full);
                            cols_q             <= tile_cols[CW-1:0];
                            bsel_q             <= bankset_sel;
                            nb_q               <= nb_in;
                            beats_sent         <= '0;
                            avm.avm_burstcount <= nb_in;
                            avm.avm_address    <= (ADDR_IS_WORD != 0) ? (aligned >> LSB) : aligned;
                        end
                    end
                end
                S_FETCH: begin
                    if (rd_valid && rd_last) begin
                        state         <= S_WRITE;
                        avm.avm_write <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (accept) begin
                        avm.avm_write <= 1'b0;
                        beats_sent    <= beats_sent + 8'd1;
                        if (more) begin
                            state <= S_FETCH;
                        end else begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tile_storer.sv
// Bench for tile_storer: BRAM and Avalon slave models, scenario tasks and a
// reference model that builds each expected beat from element index arithmetic.
module tb_tile_storer;
    localparam int W = 8, BUSW = 128, T = 16, AW = 10;
    localparam int EPP = BUSW / W, BPE = W / 8, NBYTE = BUSW / 8;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, bankset_sel = 1'b0;
    logic busy, done;
    logic [31:0] base_addr_bytes = '0;
    logic [15:0] tile_rows = '0, tile_cols = '0;
    logic [T-1:0] r_en;
    logic [T*AW-1:0] r_addr;
    logic [T*W-1:0] r_dout;

    tile_storer_if #(.BUSW(BUSW)) avm ();

    tile_storer #(.W(W), .BUSW(BUSW), .T(T), .AW(AW), .ADDR_IS_WORD(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .base_addr_bytes(base_addr_bytes), .tile_rows(tile_rows), .tile_cols(tile_cols),
        .bankset_sel(bankset_sel), .r_en(r_en), .r_addr(r_addr), .r_dout(r_dout), .avm(avm)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    logic [W-1:0] mem [T][1<<AW];

    always @(posedge clk) begin
        for (int b = 0; b < T; b++)
            if (r_en[b]) r_dout[b*W +: W] <= mem[b][r_addr[b*AW +: AW]];
    end

    logic [BUSW-1:0]  cap_data[$];
    logic [NBYTE-1:0] cap_be[$];
    logic [31:0]      cap_addr[$];
    logic [7:0]       cap_bc[$];
    int cap_hold[$], rd_bank_q[$], rd_addr_q[$];
    int done_count, unstable, onehot_bad, hold_cnt, stall_beat, stall_len, stall_left;
    bit stall_loaded, rand_wait, busy_seen, write_seen, ren_seen;
    logic [BUSW-1:0] prev_data;
    logic [NBYTE-1:0] prev_be;
    logic [31:0] prev_addr;
    logic [7:0] prev_bc;

    logic [BUSW-1:0]  exp_data[$];
    logic [NBYTE-1:0] exp_be[$];

    // Avalon slave: decide waitrequest for this cycle, then log what it sees.
    always @(negedge clk) begin : monitor
        logic wr;
        wr = 1'b0;
        if (avm.avm_write) begin
            write_seen = 1'b1;
            if (!stall_loaded && cap_data.size() == stall_beat) begin
                stall_left   = stall_len;
                stall_loaded = 1'b1;
            end
            if (stall_left > 0) begin
                wr = 1'b1;
                stall_left--;
            end else if (rand_wait) begin
                wr = ($urandom_range(0, 3) == 0);
            end
            if (hold_cnt > 0 && (avm.avm_writedata !== prev_data || avm.avm_address !== prev_addr ||
                                 avm.avm_byteenable !== prev_be || avm.avm_burstcount !== prev_bc))
                unstable++;
            prev_data = avm.avm_writedata;
            prev_addr = avm.avm_address;
            prev_be   = avm.avm_byteenable;
            prev_bc   = avm.avm_burstcount;
            hold_cnt++;
            if (!wr) begin
                cap_data.push_back(avm.avm_writedata);
                cap_be.push_back(avm.avm_byteenable);
                cap_addr.push_back(avm.avm_address);
                cap_bc.push_back(avm.avm_burstcount);
                cap_hold.push_back(hold_cnt);
                hold_cnt = 0;
            end
        end else begin
            hold_cnt = 0;
        end
        avm.avm_waitrequest = wr;
        if (done === 1'b1) done_count++;
        if (busy === 1'b1) busy_seen = 1'b1;
        if (r_en != '0) begin
            ren_seen = 1'b1;
            if (!$onehot(r_en)) onehot_bad++;
            else for (int b = 0; b < T; b++)
                if (r_en[b]) begin
                    rd_bank_q.push_back(b);
                    rd_addr_q.push_back(int'(r_addr[b*AW +: AW]));
                end
        end
    end

    task automatic clear_capture();
        cap_data.delete(); cap_be.delete(); cap_addr.delete(); cap_bc.delete();
        cap_hold.delete(); rd_bank_q.delete(); rd_addr_q.delete();
        done_count = 0; unstable = 0; onehot_bad = 0; hold_cnt = 0;
        stall_beat = -1; stall_len = 0; stall_left = 0; stall_loaded = 1'b0;
        busy_seen = 1'b0; write_seen = 1'b0; ren_seen = 1'b0;
    endtask

    task automatic fill_random();
        for (int b = 0; b < T; b++)
            for (int a = 0; a < (1 << AW); a++) mem[b][a] = W'($urandom);
    endtask

    // Reference: element k of the tile is (k/cols, k%cols); beat b holds k = b*EPP .. b*EPP+EPP-1.
    task automatic build_expected(input int rows, input int cols, input bit bsel);
        int ne, nb, k, r, c;
        logic [BUSW-1:0] d;
        logic [NBYTE-1:0] be;
        exp_data.delete(); exp_be.delete();
        ne = rows * cols;
        nb = (ne + EPP - 1) / EPP;
        for (int b = 0; b < nb; b++) begin
            d = '0; be = '0;
            for (int j = 0; j < EPP; j++) begin
                k = b * EPP + j;
                if (k < ne) begin
                    r = k / cols; c = k % cols;
                    d[j*W +: W]    = mem[r % T][int'(bsel) * (1 << (AW - 1)) + c % (1 << (AW - 1))];
                    be[j*BPE +: BPE] = '1;
                end
            end
            exp_data.push_back(d);
            exp_be.push_back(be);
        end
    endtask

    task automatic start_store(input int rows, input int cols, input bit bsel, input logic [31:0] base);
        @(negedge clk);
        tile_rows = 16'(rows); tile_cols = 16'(cols); bankset_sel = bsel; base_addr_bytes = base;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (done_count > 0) begin timed_out = 1'b0; break; end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || avm.avm_write !== 1'b0 || r_en !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b write=%b r_en=%h, required all 0", busy, done, avm.avm_write, r_en);
        end
        checks++;
        if (avm.avm_address !== 32'd0 || avm.avm_burstcount !== 8'd0 || avm.avm_byteenable !== '0) begin
            errors++;
            $display("FAIL reset_avalon: addr=%h bc=%0d be=%h, required 0", avm.avm_address, avm.avm_burstcount, avm.avm_byteenable);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_tile();
        bit to;
        logic [BUSW-1:0] lit;
        fill_random();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) mem[r][512 + c] = W'(16 * r + c);
        build_expected(16, 16, 1'b1);
        clear_capture();
        start_store(16, 16, 1'b1, 32'h1000);
        wait_done(to);
        checks++;
        if (to) begin errors++; $display("FAIL full_timeout: done not seen within budget"); end
        checks++;
        if (cap_data.size() != 16) begin errors++; $display("FAIL full_beats: got %0d beats, required 16", cap_data.size()); end
        checks++;
        if (done_count != 1) begin errors++; $display("FAIL full_done: got %0d pulses, required 1", done_count); end
        for (int b = 0; b < cap_data.size() && b < 16; b++) begin
            for (int k = 0; k < 16; k++) lit[k*8 +: 8] = 8'(16 * b + k);
            checks++;
            if (cap_data[b] !== lit || cap_data[b] !== exp_data[b]) begin
                errors++; $display("FAIL full_data beat %0d: got %h required %h", b, cap_data[b], lit);
            end
            checks++;
            if (cap_be[b] !== 16'hFFFF || cap_addr[b] !== 32'h100 || cap_bc[b] !== 8'd16 || cap_hold[b] != 1) begin
                errors++;
                $display("FAIL full_ctrl beat %0d: be=%h addr=%h bc=%0d hold=%0d, required FFFF 100 16 1",
                         b, cap_be[b], cap_addr[b], cap_bc[b], cap_hold[b]);
            end
        end
    endtask

    task automatic test_small_tile();
        bit to;
        fill_random();
        build_expected(3, 5, 1'b1);
        clear_capture();
        start_store(3, 5, 1'b1, 32'h2000);
        wait_done(to);
        checks++;
        if (to || cap_data.size() != 1) begin
            errors++; $display("FAIL small_beats: timeout=%0d beats=%0d, required 0 and 1", to, cap_data.size());
        end
        if (cap_data.size() >= 1) begin
            checks++;
            if (cap_data[0] !== exp_data[0] || cap_data[0][127:120] !== 8'h00) begin
                errors++; $display("FAIL small_data: got %h required %h", cap_data[0], exp_data[0]);
            end
            checks++;
            if (cap_be[0] !== 16'h7FFF || cap_addr[0] !== 32'h200 || cap_bc[0] !== 8'd1) begin
                errors++; $display("FAIL small_ctrl: be=%h addr=%h bc=%0d, required 7FFF 200 1", cap_be[0], cap_addr[0], cap_bc[0]);
            end
        end
        checks++;
        if (rd_bank_q.size() != 15 || onehot_bad != 0) begin
            errors++; $display("FAIL small_reads: got %0d reads (%0d not one-hot), required 15", rd_bank_q.size(), onehot_bad);
        end
        for (int k = 0; k < rd_bank_q.size() && k < 15; k++) begin
            checks++;
            if (rd_bank_q[k] != k / 5 || rd_addr_q[k] != 32'h200 + k % 5) begin
                errors++; $display("FAIL small_read %0d: bank=%0d addr=%h, required bank %0d addr %h",
                                   k, rd_bank_q[k], rd_addr_q[k], k / 5, 32'h200 + k % 5);
            end
        end
    endtask

    task automatic test_waitrequest();
        bit to;
        fill_random();
        build_expected(8, 8, 1'b0);
        clear_capture();
        stall_beat = 1; stall_len = 5;
        start_store(8, 8, 1'b0, 32'h340);
        wait_done(to);
        checks++;
        if (to || cap_data.size() != 4) begin
            errors++; $display("FAIL wait_beats: timeout=%0d beats=%0d, required 0 and 4", to, cap_data.size());
        end
        checks++;
        if (cap_hold.size() < 2 || cap_hold[1] != 6) begin
            errors++; $display("FAIL wait_hold: beat 1 held %0d cycles, required 6", (cap_hold.size() > 1) ? cap_hold[1] : -1);
        end
        checks++;
        if (unstable != 0) begin errors++; $display("FAIL wait_stable: %0d changes while stalled, required 0", unstable); end
        for (int b = 0; b < cap_data.size() && b < 4; b++) begin
            checks++;
            if (cap_data[b] !== exp_data[b] || cap_bc[b] !== 8'd4 || cap_addr[b] !== 32'h34) begin
                errors++; $display("FAIL wait_beat %0d: data=%h bc=%0d addr=%h, required %h 4 34",
                                   b, cap_data[b], cap_bc[b], cap_addr[b], exp_data[b]);
            end
        end
    endtask

    task automatic test_zero_rows();
        bit to;
        clear_capture();
        start_store(0, 7, 1'b0, 32'h500);
        wait_done(to);
        repeat (5) @(negedge clk);
        checks++;
        if (to || done_count != 1) begin errors++; $display("FAIL zero_done: timeout=%0d pulses=%0d, required 0 and 1", to, done_count); end
        checks++;
        if (write_seen || ren_seen || busy_seen) begin
            errors++; $display("FAIL zero_quiet: write=%0d r_en=%0d busy=%0d, required all 0", write_seen, ren_seen, busy_seen);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit to, hit;
        fill_random();
        clear_capture();
        start_store(16, 16, 1'b0, 32'h3000);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (cap_data.size() >= 1 && avm.avm_write === 1'b1) begin hit = 1'b1; break; end
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL rst_reach: beat 1 write never reached"); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (avm.avm_write !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rst_async: write=%b busy=%b done=%b, required 0", avm.avm_write, busy, done);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        build_expected(16, 16, 1'b1);
        clear_capture();
        start_store(16, 16, 1'b1, 32'h3000);
        wait_done(to);
        checks++;
        if (to || cap_data.size() != 16 || done_count != 1) begin
            errors++; $display("FAIL rst_rerun: timeout=%0d beats=%0d done=%0d, required 0 16 1", to, cap_data.size(), done_count);
        end
        for (int b = 0; b < cap_data.size() && b < 16; b++) begin
            checks++;
            if (cap_data[b] !== exp_data[b] || cap_addr[b] !== 32'h300 || cap_bc[b] !== 8'd16) begin
                errors++; $display("FAIL rst_beat %0d: data=%h addr=%h bc=%0d, required %h 300 16",
                                   b, cap_data[b], cap_addr[b], cap_bc[b], exp_data[b]);
            end
        end
    endtask

    task automatic test_ignore_inputs();
        bit to;
        fill_random();
        build_expected(16, 16, 1'b0);
        clear_capture();
        start_store(16, 16, 1'b0, 32'h4000);
        repeat (40) @(negedge clk);
        base_addr_bytes = 32'h8000; tile_rows = 16'd2; tile_cols = 16'd3; bankset_sel = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(to);
        repeat (30) @(negedge clk);
        checks++;
        if (to || cap_data.size() != 16 || done_count != 1) begin
            errors++; $display("FAIL ignore_beats: timeout=%0d beats=%0d done=%0d, required 0 16 1", to, cap_data.size(), done_count);
        end
        for (int b = 0; b < cap_data.size() && b < 16; b++) begin
            checks++;
            if (cap_data[b] !== exp_data[b] || cap_addr[b] !== 32'h400 || cap_bc[b] !== 8'd16) begin
                errors++; $display("FAIL ignore_beat %0d: data=%h addr=%h bc=%0d, required %h 400 16",
                                   b, cap_data[b], cap_addr[b], cap_bc[b], exp_data[b]);
            end
        end
    endtask

    task automatic test_random();
        bit to;
        int rows, cols, nb;
        bit bsel;
        logic [31:0] base;
        rand_wait = 1'b1;
        for (int it = 0; it < 6; it++) begin
            fill_random();
            rows = $urandom_range(1, 16); cols = $urandom_range(1, 16);
            bsel = 1'($urandom); base = $urandom;
            nb = (rows * cols + EPP - 1) / EPP;
            build_expected(rows, cols, bsel);
            clear_capture();
            start_store(rows, cols, bsel, base);
            wait_done(to);
            checks++;
            if (to || cap_data.size() != nb || done_count != 1 || onehot_bad != 0 || unstable != 0) begin
                errors++; $display("FAIL rand_run %0d (%0dx%0d): timeout=%0d beats=%0d done=%0d onehot_bad=%0d unstable=%0d, required beats %0d",
                                   it, rows, cols, to, cap_data.size(), done_count, onehot_bad, unstable, nb);
            end
            for (int b = 0; b < cap_data.size() && b < nb; b++) begin
                checks++;
                if (cap_data[b] !== exp_data[b] || cap_be[b] !== exp_be[b] ||
                    cap_addr[b] !== ((base & ~32'hF) >> 4) || cap_bc[b] !== 8'(nb)) begin
                    errors++; $display("FAIL rand_beat %0d.%0d: data=%h be=%h addr=%h bc=%0d, required %h %h %h %0d",
                                       it, b, cap_data[b], cap_be[b], cap_addr[b], cap_bc[b],
                                       exp_data[b], exp_be[b], (base & ~32'hF) >> 4, nb);
                end
            end
        end
        rand_wait = 1'b0;
    endtask

    initial begin
        avm.avm_waitrequest = 1'b0;
        rand_wait = 1'b0;
        clear_capture();
        test_reset();
        test_full_tile();
        test_small_tile();
        test_waitrequest();
        test_zero_rows();
        test_reset_mid_burst();
        test_ignore_inputs();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
